// File: rtl/composite_note_player_pkg.sv
// Shared types, mode encodings and constant ROM builders for the note player.
// Both ROMs are built at elaboration time, so they become plain lookup tables.
package composite_note_player_pkg;

  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int SAMPLE_W = 16;
  localparam int STEP_W   = 20;
  localparam int PHASE_W  = 22;
  localparam int FREQ_N   = 64;
  localparam int SINE_N   = 1024;

  typedef enum logic [1:0] {
    JAM_SESH    = 2'b00,
    COMPOSER    = 2'b01,
    SONG_PLAYER = 2'b11
  } mode_e;

  typedef logic [STEP_W-1:0] step_t;

  // The unused encoding 2'b10 behaves as JAM_SESH.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return COMPOSER;
      2'b11:   return SONG_PLAYER;
      default: return JAM_SESH;
    endcase
  endfunction

  // Lowest-octave steps (notes 1..12) in thousandths of a Q10.10 LSB.
  function automatic longint octave_base_milli(input int j);
    case (j)
      0:       return 64'sd9611947;
      1:       return 64'sd10183503;
      2:       return 64'sd10789045;
      3:       return 64'sd11430595;
      4:       return 64'sd12110294;
      5:       return 64'sd12830409;
      6:       return 64'sd13593345;
      7:       return 64'sd14401648;
      8:       return 64'sd15258014;
      9:       return 64'sd16165303;
      10:      return 64'sd17126542;
      default: return 64'sd18144939;
    endcase
  endfunction

  function automatic logic [FREQ_N*STEP_W-1:0] build_freq_rom();
    logic [FREQ_N*STEP_W-1:0] rom;
    longint step_milli;
    int n;
    rom = '0;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 12; j++) begin
        n = 1 + 12 * k + j;
        step_milli = octave_base_milli(j) << k;
        if (n < FREQ_N) rom[n*STEP_W +: STEP_W] = STEP_W'(step_milli / 64'sd1000);
      end
    end
    // D#3 is held at its reference tuning.
    rom[7*STEP_W +: STEP_W] = {10'd13, 10'd275};
    return rom;
  endfunction

  // Quarter-wave sine at (2i+1)*pi/4096, Taylor series in Q30, scaled to 32767.
  function automatic logic [SINE_N*SAMPLE_W-1:0] build_sine_rom();
    logic [SINE_N*SAMPLE_W-1:0] rom;
    longint x;
    longint x2;
    longint term;
    longint acc;
    int i;
    rom = '0;
    for (int hi = 0; hi < 32; hi++) begin
      for (int lo = 0; lo < 32; lo++) begin
        i    = hi * 32 + lo;
        x    = (longint'(2 * i + 1) * 64'sd3373259426) / 64'sd4096;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int t = 1; t < 5; t++) begin
          term = -((term * x2) >>> 30) / longint'((2 * t) * (2 * t + 1));
          acc  = acc + term;
        end
        rom[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'((acc * 64'sd32767) >>> 30);
      end
    end
    return rom;
  endfunction

endpackage

// File: rtl/composite_note_player_sine_reader.sv
// Phase accumulator, quarter-wave sine lookup and output sample register.
// A sample appears two cycles after its request; mute clears phase and sample.
module composite_note_player_sine_reader
  import composite_note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  step_t                      step_i,
  input  logic                       gen_i,
  input  logic                       mute_i,
  output logic signed [SAMPLE_W-1:0] sample_o
);

  localparam logic [SINE_N*SAMPLE_W-1:0] SINE_ROM = build_sine_rom();

  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic [SAMPLE_W-1:0]        rom_q, rom_d;
  logic                       neg_q, neg_d;
  logic                       gen_q;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic [9:0]                 idx;

  always_comb begin
    phase_d  = phase_q;
    rom_d    = rom_q;
    neg_d    = neg_q;
    sample_d = sample_q;
    // Quadrants 1 and 3 walk the quarter table backwards.
    idx = phase_q[20] ? ~phase_q[19:10] : phase_q[19:10];
    if (gen_i) begin
      rom_d   = SINE_ROM[int'(idx) * SAMPLE_W +: SAMPLE_W];
      neg_d   = phase_q[21];
      phase_d = phase_q + PHASE_W'(step_i);
    end
    if (gen_q) sample_d = neg_q ? -rom_q : rom_q;
    if (mute_i) begin
      phase_d  = '0;
      sample_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      rom_q    <= '0;
      neg_q    <= 1'b0;
      gen_q    <= 1'b0;
      sample_q <= '0;
    end else begin
      phase_q  <= phase_d;
      rom_q    <= rom_d;
      neg_q    <= neg_d;
      gen_q    <= gen_i & ~mute_i;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/composite_note_player.sv
// Single-voice tone generator: picks the jam or song note by mode, maps it to a
// phase step and times song-note duration in beats.
module composite_note_player
  import composite_note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       generate_next_sample,
  input  logic [11:0]                next_song_note,
  input  logic [NOTE_W-1:0]          jam_note,
  input  logic [1:0]                 state,
  input  logic                       play,
  input  logic                       beat,
  input  logic                       load_new_note,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       available
);

  localparam logic [FREQ_N*STEP_W-1:0] FREQ_ROM = build_freq_rom();

  mode_e             mode_q, mode_d;
  logic [NOTE_W-1:0] jam_q;
  logic [NOTE_W-1:0] song_note_q, song_note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  step_t             step_q, step_d;
  logic [NOTE_W-1:0] sel_note;
  logic              song_mode;
  logic              mute;

  // Handshake: available=1 means the sequencer may pulse load_new_note; the
  // load is taken that cycle and available drops on the next cycle until the
  // note's beats have elapsed.
  always_comb begin
    mode_d      = decode_mode(state);
    song_mode   = (mode_q == SONG_PLAYER);
    song_note_d = load_new_note ? next_song_note[11:6] : song_note_q;
    dur_d       = dur_q;
    if (!song_mode) begin
      dur_d = '0;
    end else if (load_new_note) begin
      dur_d = next_song_note[DUR_W-1:0];
    end else if (beat && play) begin
      dur_d = (dur_q > DUR_W'(2)) ? dur_q - DUR_W'(2) : '0;
    end
    if (song_mode) sel_note = (dur_q != '0) ? song_note_q : '0;
    else           sel_note = jam_q;
    step_d    = FREQ_ROM[int'(sel_note) * STEP_W +: STEP_W];
    mute      = ~play | (sel_note == '0);
    available = ~song_mode | (dur_q == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= JAM_SESH;
      jam_q       <= '0;
      song_note_q <= '0;
      dur_q       <= '0;
      step_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      jam_q       <= jam_note;
      song_note_q <= song_note_d;
      dur_q       <= dur_d;
      step_q      <= step_d;
    end
  end

  composite_note_player_sine_reader u_sine_reader (
    .clk      (clk),
    .reset    (reset),
    .step_i   (step_q),
    .gen_i    (generate_next_sample),
    .mute_i   (mute),
    .sample_o (sample_out)
  );

endmodule

// File: tb/tb_composite_note_player.sv
// Directed bench for composite_note_player with an expected-value queue.
module tb_composite_note_player;

  logic               clk;
  logic               reset;
  logic               generate_next_sample;
  logic [11:0]        next_song_note;
  logic [5:0]         jam_note;
  logic [1:0]         state;
  logic               play;
  logic               beat;
  logic               load_new_note;
  logic signed [15:0] sample_out;
  logic               available;

  logic [19:0]        exp_q[$];
  int                 n_cmp;
  int                 n_err;
  int                 beats;
  logic signed [15:0] prev_sample;

  composite_note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .generate_next_sample (generate_next_sample),
    .next_song_note       (next_song_note),
    .jam_note             (jam_note),
    .state                (state),
    .play                 (play),
    .beat                 (beat),
    .load_new_note        (load_new_note),
    .sample_out           (sample_out),
    .available            (available)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gen_sample();
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    tick(1);
  endtask

  task automatic pulse_beat();
    tick(5);
    beat = 1'b1;
    tick(1);
    beat = 1'b0;
  endtask

  task automatic load_pulse();
    load_new_note = 1'b1;
    tick(1);
    load_new_note = 1'b0;
  endtask

  task automatic count_beats(output int n);
    n = 0;
    while (!available && n < 12) begin
      pulse_beat();
      n++;
    end
  endtask

  // scoreboard
  task automatic check_pop(input string tag, input logic [19:0] obs);
    logic [19:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    generate_next_sample = 1'b0;
    next_song_note = '0;
    jam_note = '0;
    state = 2'b00;
    play = 1'b0;
    beat = 1'b0;
    load_new_note = 1'b0;

    #12;
    exp_q.push_back(20'd0); check_pop("reset_sample", 20'(sample_out));
    exp_q.push_back(20'd1); check_pop("reset_available", 20'(available));
    @(posedge clk); #1;
    reset = 1'b1;
    tick(1);

    // mode select
    play = 1'b1;
    jam_note = 6'd7;
    next_song_note = {6'd56, 6'd10};
    state = 2'b00;
    load_pulse();
    tick(1);
    exp_q.push_back(20'd7); check_pop("sel_jam", 20'(dut.sel_note));
    state = 2'b01;
    tick(1);
    load_pulse();
    tick(1);
    exp_q.push_back(20'd7); check_pop("sel_composer", 20'(dut.sel_note));
    state = 2'b11;
    tick(1);
    load_pulse();
    exp_q.push_back(20'd56); check_pop("sel_song", 20'(dut.sel_note));
    exp_q.push_back(20'd0);  check_pop("song_available_low", 20'(available));

    // frequency ROM
    state = 2'b00;
    jam_note = 6'd7;
    tick(2);
    exp_q.push_back({10'd13, 10'd275}); check_pop("step_n7", dut.step_q);
    exp_q.push_back(20'd1); check_pop("jam_available", 20'(available));
    jam_note = 6'd1;
    tick(2);
    exp_q.push_back({10'd9, 10'd395}); check_pop("step_n1", dut.step_q);
    jam_note = 6'd13;
    tick(2);
    exp_q.push_back({10'd18, 10'd791}); check_pop("step_n13", dut.step_q);
    jam_note = 6'd63;
    tick(2);
    exp_q.push_back({10'd337, 10'd161}); check_pop("step_n63", dut.step_q);
    jam_note = 6'd0;
    tick(2);
    exp_q.push_back(20'd0); check_pop("step_n0", dut.step_q);

    // duration: 8 half-beats consumed in 4 beats, repeated
    state = 2'b11;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      next_song_note = {6'($urandom_range(1, 63)), 6'd8};
      load_pulse();
      exp_q.push_back(20'd0); check_pop("dur_available_low", 20'(available));
      count_beats(beats);
      exp_q.push_back(20'd4); check_pop("dur_beats", 20'(beats));
    end

    // jam audio: phase starts at 0 and rises through the first quadrant
    state = 2'b00;
    jam_note = 6'd0;
    tick(2);
    jam_note = 6'd42;
    tick(2);
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    exp_q.push_back(20'd0); check_pop("sample_latency", 20'(sample_out));
    tick(1);
    exp_q.push_back(20'd25); check_pop("sample_first", 20'(sample_out));
    prev_sample = sample_out;
    for (int i = 0; i < 7; i++) begin
      tick(2);
      gen_sample();
      exp_q.push_back(20'd1); check_pop("jam_nonzero", 20'(sample_out != 16'sd0));
      exp_q.push_back(20'd1); check_pop("jam_rising", 20'(sample_out > prev_sample));
      prev_sample = sample_out;
    end
    tick(3);
    exp_q.push_back(20'(prev_sample)); check_pop("sample_hold", 20'(sample_out));
    jam_note = 6'd0;
    tick(2);
    exp_q.push_back(20'd0); check_pop("jam_release", 20'(sample_out));

    // pause mid-note
    state = 2'b11;
    tick(1);
    next_song_note = {6'd20, 6'd8};
    load_pulse();
    gen_sample();
    exp_q.push_back(20'd1); check_pop("song_nonzero", 20'(sample_out != 16'sd0));
    pulse_beat();
    play = 1'b0;
    tick(1);
    exp_q.push_back(20'd0); check_pop("pause_mute", 20'(sample_out));
    pulse_beat();
    pulse_beat();
    exp_q.push_back(20'd6); check_pop("pause_dur_held", 20'(dut.dur_q));
    exp_q.push_back(20'd0); check_pop("pause_available", 20'(available));
    gen_sample();
    exp_q.push_back(20'd0); check_pop("pause_gen_mute", 20'(sample_out));
    play = 1'b1;
    count_beats(beats);
    exp_q.push_back(20'd3); check_pop("resume_beats", 20'(beats));

    // asynchronous reset mid-note
    next_song_note = {6'd42, 6'd20};
    load_pulse();
    gen_sample();
    gen_sample();
    exp_q.push_back(20'd1); check_pop("pre_reset_nonzero", 20'(sample_out != 16'sd0));
    exp_q.push_back(20'd0); check_pop("pre_reset_available", 20'(available));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back(20'd0); check_pop("async_reset_sample", 20'(sample_out));
    exp_q.push_back(20'd1); check_pop("async_reset_available", 20'(available));
    #20;
    reset = 1'b1;
    tick(2);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
